// File: rtl/bus_mem_bridge_pkg.sv
// Shared types and constants for the core-to-memory bus bridge.
package bus_mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PC_HI,
      FETCH,
      MAR_HI,
      MAR_DEC,
      ST_HI,
      LOAD,
      HALTED
   } bridge_state_t;

   localparam int FETCH_BYTES = 4;
   localparam int LOAD_BYTES  = 2;
   localparam int CNT_W       = 2;

endpackage

// File: rtl/bus_mem_bridge_mem.sv
// Word-addressed 16-bit memory: program and store write ports, two
// combinational read ports at rd_addr and rd_addr+1 (wrapping).
module bridge_mem #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   input  logic              st_we,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [15:0]       st_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd0,
   output logic [15:0]       rd1
);

   logic [15:0]       mem [MEM_WORDS];
   logic [ADDR_W-1:0] rd_addr_p1;

   assign rd_addr_p1 = rd_addr + ADDR_W'(1);

   // Program port is applied last so it wins a same-index collision.
   always_ff @(posedge clk) begin
      if (st_we)
         mem[st_addr] <= st_data;
      if (prog_we)
         mem[prog_addr] <= prog_data;
   end

   assign rd0 = mem[rd_addr];
   assign rd1 = mem[rd_addr_p1];

endmodule

// File: rtl/bus_mem_bridge.sv
// Bus bridge between cpu_core byte bus and the program/data memory.
//
// state   | meaning
// IDLE    | waiting for a PC or MAR low byte
// PC_HI   | PC low byte held, expecting PC high byte
// FETCH   | streaming 4 bytes from mem[A], mem[A+1]
// MAR_HI  | MAR low byte held, expecting MAR high byte
// MAR_DEC | decide store (MDR strobe) or load (no strobe)
// ST_HI   | store low byte held, expecting high byte
// LOAD    | streaming 2 bytes from mem[A]
// HALTED  | core halted, only reset exits
module bus_mem_bridge
   import bus_mem_bridge_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_pc,
   input  logic              bus_mar,
   input  logic              bus_mdr,
   input  logic              halt,
   input  logic [7:0]        core_out,
   output logic [7:0]        core_in,
   output logic              data_ready,
   output logic              receive_ready,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   output logic              error
);

   bridge_state_t     state, next_state;
   logic [CNT_W-1:0]  cnt, next_cnt;
   logic              err_set, st_we;
   logic [7:0]        lo_r, st_lo;
   logic [ADDR_W-1:0] addr_r, rd_addr;
   logic [15:0]       cap_addr, rd0, rd1;
   logic [1:0]        n_strobe;
   logic              multi, any_strobe;
   logic [7:0]        nxt_core_in;
   logic              nxt_dr, nxt_rr;
   logic              unused_addr_hi;

   assign n_strobe       = {1'b0, bus_pc} + {1'b0, bus_mar} + {1'b0, bus_mdr};
   assign multi          = (n_strobe > 2'd1);
   assign any_strobe     = bus_pc | bus_mar | bus_mdr;
   assign cap_addr       = {core_out, lo_r};
   assign unused_addr_hi = ^cap_addr[15:ADDR_W];
   // The first fetch byte leaves on the same edge that captures the PC high byte.
   assign rd_addr        = (state == PC_HI) ? cap_addr[ADDR_W-1:0] : addr_r;

   bridge_mem #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_mem (
      .clk       (clk),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .st_we     (st_we),
      .st_addr   (addr_r),
      .st_data   ({core_out, st_lo}),
      .rd_addr   (rd_addr),
      .rd0       (rd0),
      .rd1       (rd1)
   );

   // State and stream counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state, error and store-write decode.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      err_set    = 1'b0;
      st_we      = 1'b0;
      case (state)
         IDLE: begin
            if (bus_pc)       next_state = PC_HI;
            else if (bus_mar) next_state = MAR_HI;
         end
         PC_HI: begin
            if (bus_pc) begin
               next_state = FETCH;
               next_cnt   = '0;
            end else begin
               err_set    = 1'b1;
               next_state = IDLE;
            end
         end
         FETCH: begin
            if (any_strobe) begin
               err_set    = 1'b1;
               next_state = IDLE;
            end else if (cnt == CNT_W'(FETCH_BYTES - 1)) begin
               next_state = IDLE;
            end else begin
               next_cnt   = cnt + CNT_W'(1);
            end
         end
         MAR_HI: begin
            if (bus_mar) begin
               next_state = MAR_DEC;
            end else begin
               err_set    = 1'b1;
               next_state = IDLE;
            end
         end
         MAR_DEC: begin
            if (bus_mdr) begin
               next_state = ST_HI;
            end else if (bus_pc || bus_mar) begin
               err_set    = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = LOAD;
               next_cnt   = '0;
            end
         end
         ST_HI: begin
            next_state = IDLE;
            if (bus_mdr) st_we   = 1'b1;
            else         err_set = 1'b1;
         end
         LOAD: begin
            if (any_strobe) begin
               err_set    = 1'b1;
               next_state = IDLE;
            end else if (cnt == CNT_W'(LOAD_BYTES - 1)) begin
               next_state = IDLE;
            end else begin
               next_cnt   = cnt + CNT_W'(1);
            end
         end
         HALTED: next_state = HALTED;
         default: next_state = IDLE;
      endcase
      if (multi && state != HALTED) begin
         err_set    = 1'b1;
         st_we      = 1'b0;
         next_state = IDLE;
      end
      if (halt) begin
         st_we      = 1'b0;
         next_state = HALTED;
      end
   end

   // Output values for the coming cycle, derived from the next state.
   always_comb begin
      nxt_core_in = 8'h00;
      nxt_dr      = 1'b0;
      nxt_rr      = (next_state == IDLE);
      case (next_state)
         FETCH: begin
            nxt_dr = 1'b1;
            case (next_cnt)
               2'd0:    nxt_core_in = rd0[7:0];
               2'd1:    nxt_core_in = rd0[15:8];
               2'd2:    nxt_core_in = rd1[7:0];
               default: nxt_core_in = rd1[15:8];
            endcase
         end
         LOAD: begin
            nxt_dr      = 1'b1;
            nxt_core_in = next_cnt[0] ? rd0[15:8] : rd0[7:0];
         end
         default: ;
      endcase
   end

   // Registered outputs; error is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_in       <= 8'h00;
         data_ready    <= 1'b0;
         receive_ready <= 1'b0;
         error         <= 1'b0;
      end else begin
         core_in       <= nxt_core_in;
         data_ready    <= nxt_dr;
         receive_ready <= nxt_rr;
         error         <= error | err_set;
      end
   end

   // Address and store-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lo_r   <= 8'h00;
         addr_r <= '0;
         st_lo  <= 8'h00;
      end else begin
         if (next_state == PC_HI || next_state == MAR_HI)
            lo_r <= core_out;
         if ((state == PC_HI && next_state == FETCH) || next_state == MAR_DEC)
            addr_r <= cap_addr[ADDR_W-1:0];
         if (next_state == ST_HI)
            st_lo <= core_out;
      end
   end

endmodule

// File: tb/tb_bus_mem_bridge.sv
// Directed plus randomized bench for bus_mem_bridge against a word-array model.
module tb_bus_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bus_pc, bus_mar, bus_mdr, halt;
   logic [7:0]  core_out, core_in;
   logic        data_ready, receive_ready, error;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] model_mem [256];
   logic        model_err;

   bus_mem_bridge #(.MEM_WORDS(256), .ADDR_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus_pc        (bus_pc),
      .bus_mar       (bus_mar),
      .bus_mdr       (bus_mdr),
      .halt          (halt),
      .core_out      (core_out),
      .core_in       (core_in),
      .data_ready    (data_ready),
      .receive_ready (receive_ready),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .error         (error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fetch_byte(input logic [15:0] a, input int k);
      logic [7:0]  idx;
      logic [15:0] w;
      idx = a[7:0] + 8'(k / 2);
      w   = model_mem[idx];
      return (k % 2 == 1) ? w[15:8] : w[7:0];
   endfunction

   task automatic clr();
      bus_pc   = 1'b0;
      bus_mar  = 1'b0;
      bus_mdr  = 1'b0;
      core_out = 8'h00;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_dr"},  16'(data_ready),    16'h0);
      chk({tag, "_in"},  16'(core_in),       16'h0);
      chk({tag, "_rr"},  16'(receive_ready), 16'h1);
      chk({tag, "_err"}, 16'(error),         16'(model_err));
   endtask

   task automatic prog_write(input logic [7:0] a, input logic [15:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic do_fetch(input logic [15:0] a);
      bus_pc   = 1'b1;
      core_out = a[7:0];
      tick();
      chk("fetch_rr_busy", 16'(receive_ready), 16'h0);
      core_out = a[15:8];
      tick();
      clr();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fetch_dr%0d", k), 16'(data_ready), 16'h1);
         chk($sformatf("fetch_b%0d@%h", k, a), 16'(core_in), 16'(fetch_byte(a, k)));
         tick();
      end
      chk_idle("fetch_end");
   endtask

   task automatic do_store(input logic [15:0] a, input logic [15:0] d);
      bus_mar  = 1'b1;
      core_out = a[7:0];
      tick();
      core_out = a[15:8];
      tick();
      bus_mar  = 1'b0;
      bus_mdr  = 1'b1;
      core_out = d[7:0];
      tick();
      core_out = d[15:8];
      tick();
      clr();
      model_mem[a[7:0]] = d;
      chk_idle("store_end");
   endtask

   task automatic do_load(input logic [15:0] a);
      bus_mar  = 1'b1;
      core_out = a[7:0];
      tick();
      core_out = a[15:8];
      tick();
      clr();
      tick();
      chk("load_dr0", 16'(data_ready), 16'h1);
      chk($sformatf("load_lo@%h", a), 16'(core_in), 16'(model_mem[a[7:0]][7:0]));
      tick();
      chk("load_dr1", 16'(data_ready), 16'h1);
      chk($sformatf("load_hi@%h", a), 16'(core_in), 16'(model_mem[a[7:0]][15:8]));
      tick();
      chk_idle("load_end");
   endtask

   initial begin
      logic [15:0] a, d, old_w;
      int          op;

      clr();
      halt      = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 8'h00;
      prog_data = 16'h0000;
      model_err = 1'b0;

      // Reset state.
      #12;
      chk("rst_in",  16'(core_in),       16'h0);
      chk("rst_dr",  16'(data_ready),    16'h0);
      chk("rst_rr",  16'(receive_ready), 16'h0);
      chk("rst_err", 16'(error),         16'h0);
      rst = 1'b1;
      #1;
      chk("rel_rr_pre", 16'(receive_ready), 16'h0);
      tick();
      chk("rel_rr_post", 16'(receive_ready), 16'h1);

      for (int i = 0; i < 256; i++)
         prog_write(8'(i), 16'($urandom));

      // Basic fetch.
      prog_write(8'h10, 16'h1234);
      prog_write(8'h11, 16'hABCD);
      do_fetch(16'h0010);

      // Store then load.
      do_store(16'h0005, 16'hBEEF);
      do_load(16'h0005);

      // Fetch wrapping past the top of memory, upper address bits ignored.
      prog_write(8'hFF, 16'h0001);
      prog_write(8'h00, 16'h0002);
      do_fetch(16'h01FF);

      // Randomized mix of operations.
      for (int i = 0; i < 24; i++) begin
         op = int'($urandom_range(0, 3));
         a  = 16'($urandom);
         d  = 16'($urandom);
         case (op)
            0: prog_write(a[7:0], d);
            1: do_fetch(a);
            2: do_store(a, d);
            default: do_load(a);
         endcase
      end

      // Program port beats a store to the same word on the same edge.
      bus_mar = 1'b1; core_out = 8'h20; tick();
      core_out = 8'h00; tick();
      bus_mar = 1'b0; bus_mdr = 1'b1; core_out = 8'h11; tick();
      core_out  = 8'h22;
      prog_we   = 1'b1;
      prog_addr = 8'h20;
      prog_data = 16'h5A5A;
      tick();
      prog_we = 1'b0;
      clr();
      model_mem[8'h20] = 16'h5A5A;
      do_load(16'h0020);

      // Read on the same edge as a program write returns the old word.
      old_w = model_mem[8'h30];
      bus_pc = 1'b1; core_out = 8'h30; tick();
      core_out  = 8'h00;
      prog_we   = 1'b1;
      prog_addr = 8'h30;
      prog_data = ~old_w;
      tick();
      prog_we = 1'b0;
      clr();
      model_mem[8'h30] = ~old_w;
      chk("rdw_b0_old", 16'(core_in), 16'(old_w[7:0]));
      tick();
      chk("rdw_b1_new", 16'(core_in), 16'(fetch_byte(16'h0030, 1)));
      tick();
      chk("rdw_b2", 16'(core_in), 16'(fetch_byte(16'h0030, 2)));
      tick();
      chk("rdw_b3", 16'(core_in), 16'(fetch_byte(16'h0030, 3)));
      tick();
      chk_idle("rdw_end");

      // Protocol error: PC low byte with no high byte.
      bus_pc = 1'b1; core_out = 8'h44; tick();
      clr();
      tick();
      model_err = 1'b1;
      chk("perr_err", 16'(error), 16'h1);
      chk("perr_rr",  16'(receive_ready), 16'h1);
      do_fetch(16'($urandom));

      // Reset between MAR high byte and MDR high byte drops the store.
      bus_mar = 1'b1; core_out = 8'h40; tick();
      core_out = 8'h00; tick();
      bus_mar = 1'b0; bus_mdr = 1'b1; core_out = 8'h99; tick();
      clr();
      rst = 1'b0;
      #1;
      model_err = 1'b0;
      chk("mrst_in",  16'(core_in),       16'h0);
      chk("mrst_dr",  16'(data_ready),    16'h0);
      chk("mrst_rr",  16'(receive_ready), 16'h0);
      chk("mrst_err", 16'(error),         16'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_rr_pre", 16'(receive_ready), 16'h0);
      tick();
      chk("mrst_rr_post", 16'(receive_ready), 16'h1);
      do_load(16'h0040);

      // Two strobes together on the store high byte: error, no write.
      bus_mar = 1'b1; core_out = 8'h41; tick();
      core_out = 8'h00; tick();
      bus_mar = 1'b0; bus_mdr = 1'b1; core_out = 8'h66; tick();
      bus_pc = 1'b1; core_out = 8'h77; tick();
      clr();
      model_err = 1'b1;
      chk("multi_err", 16'(error), 16'h1);
      chk("multi_rr",  16'(receive_ready), 16'h1);
      do_load(16'h0041);

      // Halt during the second fetch byte.
      bus_pc = 1'b1; core_out = 8'h50; tick();
      core_out = 8'h00; tick();
      clr();
      chk("halt_b0", 16'(core_in), 16'(fetch_byte(16'h0050, 0)));
      tick();
      chk("halt_b1_dr", 16'(data_ready), 16'h1);
      chk("halt_b1", 16'(core_in), 16'(fetch_byte(16'h0050, 1)));
      halt = 1'b1;
      tick();
      chk("halted_dr",  16'(data_ready),    16'h0);
      chk("halted_in",  16'(core_in),       16'h0);
      chk("halted_rr",  16'(receive_ready), 16'h0);
      chk("halted_err", 16'(error),         16'h1);
      halt = 1'b0;
      tick();
      chk("halted_stay_rr", 16'(receive_ready), 16'h0);
      bus_pc = 1'b1; core_out = 8'h03; tick();
      clr();
      chk("halted_ignore_dr", 16'(data_ready), 16'h0);
      prog_write(8'h03, 16'h7777);
      tick();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      model_err = 1'b0;
      tick();
      do_fetch(16'h0003);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
